// File: rtl/rv32_pkg.sv
// Shared data-memory request/response types and defaults for the rv32 core slice.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rv32_pkg;

    // Default accept-to-response latency of the data memory.
    localparam int DMEM_DEFAULT_LATENCY = 2;

    typedef struct packed {
        logic [31:0] addr;   // byte address
        logic        we;     // 1 = store, 0 = load
        logic [3:0]  wstrb;  // byte-lane write enables
        logic [31:0] wdata;  // lane-aligned store data
    } dmem_req_t;

    typedef struct packed {
        logic [31:0] rdata;  // load data, 0 for stores and errors
        logic        err;    // error response
    } dmem_rsp_t;

    // Byte-lane merge of store data into an existing word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
                merged[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// Synchronous FIFO of dmem_rsp_t entries with occupancy count and full/empty flags.
// Latency: a write is visible at rd_dat on the cycle after the write edge.
// Backpressure: rd_rdy pops the head when non-empty; writing while full is illegal (asserted).
//
// Ports: clk, resetn (async active low), wr_vld/wr_dat push side,
//        rd_rdy/rd_dat pop side (rd_dat = head), count/full/empty status.
module dmem_rsp_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         wr_vld,
    input  dmem_rsp_t                    wr_dat,
    input  logic                         rd_rdy,
    output dmem_rsp_t                    rd_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    dmem_rsp_t         buf_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              push;
    logic              pop;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign push   = wr_vld;
    assign pop    = rd_rdy && !empty;
    assign rd_dat = buf_q[rd_ptr_q];

    // Pointers wrap explicitly so that DEPTH = 1 works too.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_next(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; only entries between the pointers are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr_q] <= wr_dat;
        end
    end

    // The responder's credit count guarantees a slot for every response.
    a_no_overflow: assert property (@(posedge clk) disable iff (!resetn) !(wr_vld && full));

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: SRAM array plus in-order response buffer behind a credit counter.
// Latency: request accepted at edge k -> response at the FIFO head after edge k+LATENCY.
// Backpressure: req_ready drops when RSP_FIFO_DEPTH responses are outstanding; rsp_* held until rsp_ready.
//
// Ports: clk, resetn (async active low); req_valid/req_ready/req_addr/req_we/req_wstrb/req_wdata
//        request side; rsp_valid/rsp_ready/rsp_rdata/rsp_err response side.
// Build option: define DMEM_ERR_EN to flag misaligned / out-of-range accesses with rsp_err;
//        otherwise addr[1:0] is ignored, the word index wraps and rsp_err is tied 0.
module dmem_responder
    import rv32_pkg::*;
#(
    parameter int DEPTH_WORDS    = 1024,
    parameter int LATENCY        = DMEM_DEFAULT_LATENCY,  // 1..4
    parameter int RSP_FIFO_DEPTH = 4                      // >= LATENCY
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(RSP_FIFO_DEPTH + 1);

    dmem_req_t          req;
    logic               accept;
    logic               rsp_pop;
    logic [AW-1:0]      idx;
    logic               addr_err;
    logic               live_q;
    logic [CW-1:0]      cnt_q;

    logic [31:0]        mem [DEPTH_WORDS];

    logic [LATENCY-1:0] pipe_vld;
    dmem_rsp_t          pipe_dat [LATENCY];

    dmem_rsp_t          head;
    logic [CW-1:0]      unused_fifo_count;
    logic               unused_fifo_full;
    logic               fifo_empty;
    logic               unused_status;

    assign req = '{addr: req_addr, we: req_we, wstrb: req_wstrb, wdata: req_wdata};
    assign idx = req.addr[2 +: AW];

`ifdef DMEM_ERR_EN
    assign addr_err = (req.addr[1:0] != 2'b00) || (req.addr >= 32'(4 * DEPTH_WORDS));
    assign rsp_err  = !fifo_empty && head.err;
    assign unused_status = ^{unused_fifo_count, unused_fifo_full};
`else
    assign addr_err = 1'b0;
    assign rsp_err  = 1'b0;
    assign unused_status = ^{unused_fifo_count, unused_fifo_full, head.err,
                             req.addr[31:2+AW], req.addr[1:0]};
`endif

    // Credit: cnt counts everything accepted but not yet handed over, so the
    // FIFO always has room for whatever is still in the delay line.
    // live_q keeps req_ready low during reset and releases it one edge later.
    assign req_ready = live_q && (cnt_q < CW'(RSP_FIFO_DEPTH));
    assign accept    = req_valid && req_ready;
    assign rsp_pop   = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            live_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            live_q <= 1'b1;
            case ({accept, rsp_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Array: contents survive reset. Stores merge byte lanes at the accept edge.
    always_ff @(posedge clk) begin
        if (accept && req.we && !addr_err) begin
            mem[idx] <= merge_bytes(mem[idx], req.wdata, req.wstrb);
        end
    end

    // Stage 0 is the array read register captured at the accept edge; the
    // remaining LATENCY-1 stages form the delay line feeding the FIFO.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pipe_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= accept;
            pipe_dat[0] <= '{rdata: (accept && !req.we && !addr_err) ? mem[idx] : 32'h0,
                             err:   accept && addr_err};
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    dmem_rsp_fifo #(
        .DEPTH (RSP_FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk    (clk),
        .resetn (resetn),
        .wr_vld (pipe_vld[LATENCY-1]),
        .wr_dat (pipe_dat[LATENCY-1]),
        .rd_rdy (rsp_ready),
        .rd_dat (head),
        .count  (unused_fifo_count),
        .full   (unused_fifo_full),
        .empty  (fifo_empty)
    );

    assign rsp_valid = !fifo_empty;
    // Head storage is not reset, so mask it while nothing is buffered.
    assign rsp_rdata = fifo_empty ? 32'h0 : head.rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=2, RSP_FIFO_DEPTH=4, DEPTH_WORDS=1024).
// Latency: n/a.
// Backpressure: exercised through rsp_ready stalls and credit exhaustion.
module tb_dmem_responder;

    localparam int LAT = 2;
    localparam int FD  = 4;
    localparam int DW  = 1024;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;
    logic [31:0] rx [16];

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS    (DW),
        .LATENCY        (LAT),
        .RSP_FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wstrb (req_wstrb),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic send(input logic [31:0] a, input logic we, input logic [3:0] s, input logic [31:0] d);
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = we;
        req_wstrb = s;
        req_wdata = d;
        for (int i = 0; i < 50 && !req_ready; i++) tick();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready addr=%h: req_ready=%b, required 1", a, req_ready);
        end
        tick();
        req_valid = 1'b0;
    endtask

    // Capture the next response (rsp_ready must be 1), bounded wait.
    task automatic wait_rsp(output logic [31:0] d, output logic e);
        bit got;
        got = 1'b0;
        d = '0;
        e = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (rsp_valid && rsp_ready) begin
                d = rsp_rdata;
                e = rsp_err;
                got = 1'b1;
            end
            tick();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wait_rsp: no response within 30 cycles, required one");
        end
    endtask

    task automatic test_reset();
        int seen;
        resetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
        req_wstrb = '0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (3) tick();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b, required 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b, required 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata: got %h, required 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b, required 0", rsp_err); end
        resetn = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rel_ready_early: got %b, required 0", req_ready); end
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b, required 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rel_rsp_valid: got %b, required 0", rsp_valid); end

        // Mid-burst reset with three loads pending.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_addr = 32'(4 * i);
            tick();
        end
        req_valid = 1'b0;
        repeat (3) tick();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_pending: rsp_valid=%b, required 1", rsp_valid); end
        resetn = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_async: rsp_valid=%b, required 0", rsp_valid); end
        repeat (2) tick();
        resetn = 1'b1;
        rsp_ready = 1'b1;
        tick();
        seen = 0;
        repeat (10) begin
            if (rsp_valid) seen++;
            tick();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL mid_discard: %0d response cycles, required 0", seen); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b, required 1", req_ready); end
    endtask

    task automatic test_store_load();
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h10; req_we = 1'b1; req_wstrb = 4'hF; req_wdata = 32'hDEADBEEF;
        tick();                                            // store accepted at edge k
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sl_k: rsp_valid=%b, required 0", rsp_valid); end
        req_we = 1'b0;
        tick();                                            // load accepted at edge k+1
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sl_k1: rsp_valid=%b, required 0", rsp_valid); end
        tick();                                            // k+2: store response
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL sl_st_valid: got %b, required 1", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL sl_st_rdata: got %h, required 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL sl_st_err: got %b, required 0", rsp_err); end
        tick();                                            // k+3: load response
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL sl_ld_valid: got %b, required 1", rsp_valid); end
        checks++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sl_ld_rdata: got %h, required deadbeef", rsp_rdata); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sl_idle: rsp_valid=%b, required 0", rsp_valid); end
    endtask

    task automatic test_byte_merge();
        logic [31:0] d1, d2, d3;
        logic        e1, e2, e3;
        rsp_ready = 1'b1;
        send(32'h20, 1'b1, 4'hF, 32'h11223344);
        send(32'h20, 1'b1, 4'h1, 32'h000000AA);
        send(32'h20, 1'b0, 4'h0, 32'h0);
        wait_rsp(d1, e1);
        wait_rsp(d2, e2);
        wait_rsp(d3, e3);
        checks++; if (d1 !== 32'h0 || d2 !== 32'h0) begin errors++; $display("FAIL bm_store_rdata: got %h %h, required 0 0", d1, d2); end
        checks++; if (d3 !== 32'h112233AA) begin errors++; $display("FAIL bm_merge: got %h, required 112233aa", d3); end
        checks++; if ({e1, e2, e3} !== 3'b000) begin errors++; $display("FAIL bm_err: got %b, required 000", {e1, e2, e3}); end
        // wstrb = 0 store leaves the word untouched.
        send(32'h20, 1'b1, 4'h0, 32'hFFFFFFFF);
        send(32'h20, 1'b0, 4'h0, 32'h0);
        wait_rsp(d1, e1);
        wait_rsp(d2, e2);
        checks++; if (d2 !== 32'h112233AA) begin errors++; $display("FAIL bm_noop: got %h, required 112233aa", d2); end
    endtask

    task automatic test_backpressure();
        int  accepted;
        int  got;
        bit  acc_now;
        bit  hs;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(32'h100 + 32'(4 * i), 1'b1, 4'hF, 32'hA0000000 + 32'(i));
        repeat (LAT + 2) tick();

        rsp_ready = 1'b0;
        accepted = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100;
        repeat (10) begin
            acc_now = req_valid && req_ready;
            tick();
            if (acc_now) begin
                accepted++;
                req_addr = 32'h100 + 32'(4 * accepted);
            end
        end
        checks++; if (accepted != FD) begin errors++; $display("FAIL bp_accepted: got %0d, required %0d", accepted, FD); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b, required 0", req_ready); end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b, required 1", rsp_valid); end
        checks++; if (rsp_rdata !== 32'hA0000000) begin errors++; $display("FAIL bp_head: got %h, required a0000000", rsp_rdata); end

        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            hs = rsp_valid && rsp_ready;
            acc_now = req_valid && req_ready;
            if (hs) rx[got] = rsp_rdata;
            tick();
            if (hs) got++;
            if (acc_now) begin
                accepted++;
                if (accepted >= 6) req_valid = 1'b0;
                else req_addr = 32'h100 + 32'(4 * accepted);
            end
        end
        req_valid = 1'b0;
        checks++; if (got != 6) begin errors++; $display("FAIL bp_rsp_count: got %0d, required 6", got); end
        checks++; if (accepted != 6) begin errors++; $display("FAIL bp_total_accepted: got %0d, required 6", accepted); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (rx[i] !== 32'hA0000000 + 32'(i)) begin
                errors++;
                $display("FAIL bp_order[%0d]: got %h, required %h", i, rx[i], 32'hA0000000 + 32'(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        int stalls;
        int gaps;
        int nrx;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_addr = 32'h100 + 32'(4 * i);
            tick();
        end
        req_valid = 1'b0;
        repeat (LAT + 1) tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_at3: got %b, required 1", req_ready); end

        rsp_ready = 1'b1;
        req_valid = 1'b1;
        stalls = 0; gaps = 0; nrx = 0;
        for (int s = 0; s < 8; s++) begin
            req_addr = 32'h100 + 32'(4 * ((3 + s) % 6));
            if (!req_ready) stalls++;
            if (rsp_valid) begin
                rx[nrx] = rsp_rdata;
                nrx++;
            end else begin
                gaps++;
            end
            tick();
        end
        req_valid = 1'b0;
        for (int c = 0; c < 20 && nrx < 11; c++) begin
            if (rsp_valid) begin
                rx[nrx] = rsp_rdata;
                nrx++;
            end
            tick();
        end
        checks++; if (stalls != 0) begin errors++; $display("FAIL b2b_stalls: %0d cycles with req_ready=0, required 0", stalls); end
        checks++; if (gaps != 0) begin errors++; $display("FAIL b2b_gaps: %0d cycles without response, required 0", gaps); end
        checks++; if (nrx != 11) begin errors++; $display("FAIL b2b_count: got %0d, required 11", nrx); end
        for (int i = 0; i < 11 && i < nrx; i++) begin
            checks++;
            if (rx[i] !== 32'hA0000000 + 32'(i % 6)) begin
                errors++;
                $display("FAIL b2b_order[%0d]: got %h, required %h", i, rx[i], 32'hA0000000 + 32'(i % 6));
            end
        end
    endtask

    task automatic test_addr_range();
        logic [31:0] d1, d2, d3, d4, d5;
        logic        e1, e2, e3, e4, e5;
        rsp_ready = 1'b1;
`ifdef DMEM_ERR_EN
        send(32'h0, 1'b1, 4'hF, 32'hCAFEF00D);
        send(32'h13, 1'b0, 4'h0, 32'h0);
        send(32'(4 * DW), 1'b0, 4'h0, 32'h0);
        send(32'(4 * DW), 1'b1, 4'hF, 32'h12345678);
        send(32'h0, 1'b0, 4'h0, 32'h0);
        wait_rsp(d1, e1);
        wait_rsp(d2, e2);
        wait_rsp(d3, e3);
        wait_rsp(d4, e4);
        wait_rsp(d5, e5);
        checks++; if (e1 !== 1'b0) begin errors++; $display("FAIL er_store_ok: err=%b, required 0", e1); end
        checks++; if ({e2, d2} !== {1'b1, 32'h0}) begin errors++; $display("FAIL er_misaligned: err=%b rdata=%h, required 1 0", e2, d2); end
        checks++; if ({e3, d3} !== {1'b1, 32'h0}) begin errors++; $display("FAIL er_range_ld: err=%b rdata=%h, required 1 0", e3, d3); end
        checks++; if (e4 !== 1'b1) begin errors++; $display("FAIL er_range_st: err=%b, required 1", e4); end
        checks++; if ({e5, d5} !== {1'b0, 32'hCAFEF00D}) begin errors++; $display("FAIL er_unchanged: err=%b rdata=%h, required 0 cafef00d", e5, d5); end
`else
        send(32'h0, 1'b1, 4'hF, 32'hCAFEF00D);
        send(32'(4 * DW), 1'b0, 4'h0, 32'h0);
        send(32'h13, 1'b0, 4'h0, 32'h0);
        wait_rsp(d1, e1);
        wait_rsp(d2, e2);
        wait_rsp(d3, e3);
        d4 = '0; e4 = 1'b0; d5 = '0; e5 = 1'b0;
        checks++; if ({e2, d2} !== {1'b0, 32'hCAFEF00D}) begin errors++; $display("FAIL wrap_load: err=%b rdata=%h, required 0 cafef00d", e2, d2); end
        checks++; if ({e3, d3} !== {1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL lowbits_ignored: err=%b rdata=%h, required 0 deadbeef", e3, d3); end
        checks++; if ({e1, e4, e5} !== 3'b000) begin errors++; $display("FAIL noerr_tied: err=%b, required 0", e1); end
`endif
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_merge();
        test_backpressure();
        test_back_to_back();
        test_addr_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
